parking_gate_arbiter: RTL
=========================

# parking_gate_arbiter

Controller that shares the single parking barrier between an entry lane and an exit lane. It arbitrates lane requests round-robin and issues a one-cycle `bariera` open pulse for the winning lane. It then waits for the vehicle-passage sensor and maintains the occupied-space count driven to the display (`afisare_locuri`) and the `parcare_full` flag. It sits between the lane request logic/sensors and the output interface monitored by the bench.

## Interface
- `CAPACITY`, default 255: maximum occupied spaces, legal range 1..255; `parcare_full` asserts when the count equals `CAPACITY`.
- `TIMEOUT`, default 16: cycles to wait in WAIT_PASS for the sensor before abandoning the passage, legal range 1..255.

- `clk` input 1: single clock; all logic on posedge.
- `reset` input 1: synchronous, active-high.
- `req_in` input 1: entry-lane request, level, held until `gnt_in`.
- `req_out` input 1: exit-lane request, level, held until `gnt_out`.
- `senzor_trecere` input 1: vehicle-passed sensor, one-cycle pulse.
- `gnt_in` output 1: one-cycle grant to the entry lane.
- `gnt_out` output 1: one-cycle grant to the exit lane.
- `bariera` output 1: barrier open command, one-cycle pulse.
- `afisare_locuri` output 8: occupied-space count.
- `parcare_full` output 1: asserted when the count equals `CAPACITY`.
- `timeout` output 1: one-cycle pulse when a passage is abandoned.
- `busy` output 1: high in every state except IDLE.

## Operation
- There is one clock (`clk`). Reset is synchronous and active-high (`reset`).
- States: IDLE, OPEN, WAIT_PASS.
- **Eligibility:**
  - Entry is eligible when `req_in` is high and `parcare_full` is low.
  - Exit is eligible when `req_out` is high and the count is greater than 0.
  - Ineligible requests are never granted and stay pending without error.
- **IDLE:**
  - If exactly one lane is eligible, that lane wins.
  - If both are eligible, the lane not served last wins.
  - After reset, the last-served pointer is set to exit, so entry wins the first tie.
  - When there is a winner, go to OPEN and record the lane; the pointer updates on every grant.
- **OPEN** (exactly 1 cycle): `bariera`=1 and the matching `gnt_*`=1. Then go to WAIT_PASS with the wait counter cleared.
- **WAIT_PASS:**
  - If `senzor_trecere`=1: an entry passage increments the count and an exit passage decrements it. Go to IDLE.
  - Otherwise the wait counter increments. When it reaches `TIMEOUT`, pulse `timeout`=1, leave the count unchanged, and go to IDLE.
- `senzor_trecere` outside WAIT_PASS is ignored.
- Count arithmetic is 8-bit unsigned. The count never exceeds `CAPACITY` and never goes below 0, because eligibility is checked at grant time. Overflow and underflow are unreachable; the verifier asserts this.
- `afisare_locuri` is the count register. `parcare_full` is registered and updates in the same cycle as the count.
- With `CAPACITY`=255, `afisare_locuri`==255 implies `parcare_full`=1.
- Reset mid-operation (any state) returns the block to IDLE with count 0 and pointer = exit. An in-flight passage is discarded.

## Timing
- Reset values: `gnt_in`=0, `gnt_out`=0, `bariera`=0, `afisare_locuri`=0, `parcare_full`=0, `timeout`=0, `busy`=0.
- All outputs are registered.
- **Grant latency:** a request sampled in IDLE at edge t produces `bariera` and `gnt_*` high in the cycle after t, for exactly one cycle.
- `bariera` is never high in two consecutive cycles. OPEN is always followed by at least one WAIT_PASS cycle.
- **Count update:** a sensor pulse sampled at edge k gives the new `afisare_locuri`/`parcare_full` after edge k, and the block is in IDLE after edge k.
  - The next grant can be sampled at edge k+1, so `bariera` rises at the earliest 2 cycles after the sensor pulse.
- **Timeout:** abandonment occurs `TIMEOUT` cycles after entering WAIT_PASS, with `timeout` high for 1 cycle.
  - If the sensor pulse and timeout expiry coincide, the sensor wins: count updates and no `timeout` pulse.
- Eligibility uses the registered count. An entry is never granted in the same cycle a passage fills the lot.

## Test plan
- **Reset:** assert `reset` for 2 cycles with `req_in`=1 -> all outputs 0 and no grant during reset; `gnt_in` pulses 1 cycle after release.
- **Single entry:** `req_in`=1 at count 0 -> `bariera`+`gnt_in` for 1 cycle; `senzor_trecere` 3 cycles later -> `afisare_locuri`=1 on the next cycle, `busy`=0.
- **Fill and drain:** with `CAPACITY`=3, perform 3 entries -> `afisare_locuri`=3 and `parcare_full`=1.
  - Hold `req_in` high for 20 cycles -> no grant.
  - One exit -> count 2, `parcare_full`=0, and the pending entry is granted next.
- **Round-robin:** with count 1, hold `req_in` and `req_out` high continuously, each followed by a sensor pulse -> grants alternate entry, exit, entry, exit; count toggles between 2 and 1.
- **Timeout:** with `TIMEOUT`=4, grant entry with no sensor -> `timeout` pulses 4 cycles after entering WAIT_PASS; count unchanged; a sensor pulse 2 cycles later is ignored.
- **Reset in WAIT_PASS:** assert `reset` after a grant, then pulse the sensor after release -> count stays 0 and state is IDLE; the simultaneous-sensor/timeout-expiry case increments the count with no `timeout` pulse.

Source files
------------

// File: rtl/parking_gate_arbiter_if.sv
// Lane request/grant, passage sensor and display signals of the parking barrier arbiter.
// The slave modport is the arbiter's view; the master modport is the lane/sensor side.
interface parking_gate_arbiter_if;
  logic       req_in;
  logic       req_out;
  logic       senzor_trecere;
  logic       gnt_in;
  logic       gnt_out;
  logic       bariera;
  logic [7:0] afisare_locuri;
  logic       parcare_full;
  logic       timeout;
  logic       busy;

  modport master (
    output req_in,
    output req_out,
    output senzor_trecere,
    input  gnt_in,
    input  gnt_out,
    input  bariera,
    input  afisare_locuri,
    input  parcare_full,
    input  timeout,
    input  busy
  );

  modport slave (
    input  req_in,
    input  req_out,
    input  senzor_trecere,
    output gnt_in,
    output gnt_out,
    output bariera,
    output afisare_locuri,
    output parcare_full,
    output timeout,
    output busy
  );
endinterface

// File: rtl/parking_gate_arbiter.sv
// Round-robin arbiter sharing one parking barrier between entry and exit lanes,
// tracking occupied spaces and abandoning passages that never reach the sensor.
module parking_gate_arbiter #(
  parameter int unsigned CAPACITY = 255,
  parameter int unsigned TIMEOUT  = 16
) (
  input logic                   clk,
  input logic                   reset,
  parking_gate_arbiter_if.slave bus
);

  localparam logic [7:0] CapVal     = 8'(CAPACITY);
  localparam logic [7:0] TimeoutVal = 8'(TIMEOUT);

  typedef enum logic [1:0] {StIdle, StOpen, StWaitPass} state_e;

  state_e     state_q;
  logic [7:0] count_q;
  logic [7:0] wait_q;
  logic       full_q;
  logic       last_exit_q;
  logic       lane_exit_q;
  logic       gnt_in_q;
  logic       gnt_out_q;
  logic       bariera_q;
  logic       timeout_q;
  logic       busy_q;

  logic       elig_in;
  logic       elig_out;
  logic       win;
  logic       pick_exit;
  logic [7:0] count_d;
  logic [7:0] wait_d;

  // Eligibility is judged on the registered count, so a passage that fills the
  // lot can never race with an entry grant.
  always_comb begin
    elig_in   = bus.req_in & ~full_q;
    elig_out  = bus.req_out & (count_q != 8'd0);
    win       = elig_in | elig_out;
    pick_exit = elig_out & (~elig_in | ~last_exit_q);
    count_d   = lane_exit_q ? (count_q - 8'd1) : (count_q + 8'd1);
    wait_d    = wait_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      count_q     <= 8'd0;
      wait_q      <= 8'd0;
      full_q      <= 1'b0;
      last_exit_q <= 1'b1;
      lane_exit_q <= 1'b0;
      gnt_in_q    <= 1'b0;
      gnt_out_q   <= 1'b0;
      bariera_q   <= 1'b0;
      timeout_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      gnt_in_q  <= 1'b0;
      gnt_out_q <= 1'b0;
      bariera_q <= 1'b0;
      timeout_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (win) begin
            state_q     <= StOpen;
            lane_exit_q <= pick_exit;
            last_exit_q <= pick_exit;
            gnt_in_q    <= ~pick_exit;
            gnt_out_q   <= pick_exit;
            bariera_q   <= 1'b1;
            busy_q      <= 1'b1;
          end
        end
        StOpen: begin
          state_q <= StWaitPass;
          wait_q  <= 8'd0;
        end
        StWaitPass: begin
          // Sensor takes priority over a timeout expiring on the same edge.
          if (bus.senzor_trecere) begin
            count_q <= count_d;
            full_q  <= (count_d == CapVal);
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end else if (wait_d == TimeoutVal) begin
            timeout_q <= 1'b1;
            state_q   <= StIdle;
            busy_q    <= 1'b0;
          end else begin
            wait_q <= wait_d;
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.gnt_in         = gnt_in_q;
  assign bus.gnt_out        = gnt_out_q;
  assign bus.bariera        = bariera_q;
  assign bus.afisare_locuri = count_q;
  assign bus.parcare_full   = full_q;
  assign bus.timeout        = timeout_q;
  assign bus.busy           = busy_q;

endmodule
